// File: rtl/sobol_share_sched.sv
// ============================================================================
// Module   : sobol_share_sched
// Brief    : Round-robin sharing of one Sobol FP16 generator among NUM_REQ
//            consumers. Optional point counter under SOBOL_SHARE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sobol_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int GEN_LAT = 2,
    parameter int DISCARD = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gen_clr,
    output logic               gen_start,
    input  logic [15:0]        gen_fp16,
    output logic [NUM_REQ-1:0] smp_vld,
    output logic [15:0]        smp_data,
    output logic               busy
`ifdef SOBOL_SHARE_CNT_EN
    ,
    output logic [31:0]        pt_idx,
    output logic               sat
`endif
);

    localparam int         c_ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int         c_TAIL      = GEN_LAT - 1;
    localparam logic [7:0] c_WAIT_LAST = 8'(GEN_LAT - 1);
    localparam logic [7:0] c_SKIP_LAST = 8'(DISCARD - 1);

    typedef enum logic [1:0] {
        S_CLR  = 2'd0,
        S_WAIT = 2'd1,
        S_SKIP = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic                 w_found;
    logic [c_ID_W-1:0]    w_off;
    logic [c_ID_W:0]      w_sum;
    logic [c_ID_W-1:0]    w_win;
    logic [c_ID_W-1:0]    w_ptr_nxt;

    logic                 w_live;
    logic                 w_start;
    logic                 w_drop;
    logic                 w_clr;
    logic                 w_grant;

    logic [GEN_LAT-1:0]             r_tv;
    logic [GEN_LAT-1:0]             r_td;
    logic [GEN_LAT-1:0][c_ID_W-1:0] r_tid;
    logic                           w_tail_ok;
    logic [15:0]                    r_last;

    // Reset and restart both suppress every issue in the cycle they are seen.
    assign w_live = ~rst & ~restart;

    // Rotate the request vector so bit 0 is the current round-robin head.
    always_comb begin
        w_dbl   = {req, req};
        w_rot   = NUM_REQ'(w_dbl >> r_rr_ptr);
        w_found = 1'b0;
        w_off   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_off   = c_ID_W'(i);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (c_ID_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (c_ID_W+1)'(NUM_REQ);
        end
        w_win     = w_sum[c_ID_W-1:0];
        w_ptr_nxt = (w_win == c_ID_W'(NUM_REQ - 1)) ? '0 : w_win + c_ID_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_drop      = 1'b0;
        w_clr       = 1'b0;
        w_grant     = 1'b0;
        case (r_state)
            S_CLR: begin
                w_clr       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (DISCARD == 0) ? S_RUN : S_SKIP;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_SKIP: begin
                w_start = 1'b1;
                w_drop  = 1'b1;
                if (r_cnt == c_SKIP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RUN: begin
                w_grant = w_found;
                w_start = w_found;
            end
            default: w_state_nxt = S_CLR;
        endcase
        if (!w_live) begin
            w_state_nxt = S_CLR;
            w_cnt_nxt   = '0;
            w_start     = 1'b0;
            w_drop      = 1'b0;
            w_clr       = 1'b0;
            w_grant     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_CLR;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    // Tag pipeline mirrors the generator latency: {valid, drop, id}.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_tv  <= '0;
            r_td  <= '0;
            r_tid <= '0;
        end else begin
            r_tv[0]  <= w_start;
            r_td[0]  <= w_drop;
            r_tid[0] <= w_win;
            for (int k = 1; k < GEN_LAT; k++) begin
                r_tv[k]  <= r_tv[k-1];
                r_td[k]  <= r_td[k-1];
                r_tid[k] <= r_tid[k-1];
            end
        end
    end

    assign w_tail_ok = r_tv[c_TAIL] & ~r_td[c_TAIL] & w_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (w_tail_ok) begin
            r_last <= gen_fp16;
        end
    end

    assign gnt       = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    assign gen_start = w_start;
    assign gen_clr   = w_clr;
    assign smp_vld   = w_tail_ok ? (NUM_REQ'(1) << r_tid[c_TAIL]) : '0;
    assign smp_data  = w_tail_ok ? gen_fp16 : r_last;
    assign busy      = ~rst & (r_state != S_RUN);

`ifdef SOBOL_SHARE_CNT_EN
    logic [31:0] r_pt;
    logic        r_sat;

    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt == S_CLR)) begin
            r_pt  <= '0;
            r_sat <= 1'b0;
        end else if (w_start) begin
            r_pt <= r_pt + 32'd1;
            if (r_pt == 32'hFFFF_FFFF) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign pt_idx = r_pt;
    assign sat    = r_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sobol_share_sched.sv
// ============================================================================
// Module   : tb_sobol_share_sched
// Brief    : Directed self-checking bench for sobol_share_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sobol_share_sched;

    localparam int NUM_REQ = 4;
    localparam int GEN_LAT = 2;
    localparam int DISCARD = 1;

    localparam logic [3:0] G_ALL [10] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    localparam logic [3:0] V_ALL [10] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    localparam logic [3:0] G_ALT [6]  = '{4'h1, 4'h4, 4'h1, 4'h4, 4'h0, 4'h0};
    localparam logic [3:0] V_ALT [6]  = '{4'h0, 4'h0, 4'h1, 4'h4, 4'h1, 4'h4};
    localparam logic [3:0] G_RS  [7]  = '{4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0};
    localparam logic [3:0] V_RS  [7]  = '{4'h0, 4'h0, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        restart = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] gen_fp16 = '0;
    logic [3:0]  gnt;
    logic        gen_clr;
    logic        gen_start;
    logic [3:0]  smp_vld;
    logic [15:0] smp_data;
    logic        busy;
`ifdef SOBOL_SHARE_CNT_EN
    logic [31:0] pt_idx;
    logic        sat;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] last_data = '0;

    sobol_share_sched #(
        .NUM_REQ (NUM_REQ),
        .GEN_LAT (GEN_LAT),
        .DISCARD (DISCARD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart),
        .req       (req),
        .gnt       (gnt),
        .gen_clr   (gen_clr),
        .gen_start (gen_start),
        .gen_fp16  (gen_fp16),
        .smp_vld   (smp_vld),
        .smp_data  (smp_data),
        .busy      (busy)
`ifdef SOBOL_SHARE_CNT_EN
        ,
        .pt_idx    (pt_idx),
        .sat       (sat)
`endif
    );

    always #5 clk = ~clk;

    // Generator output is a distinct, time-varying pattern per cycle.
    function automatic logic [15:0] fp_at(input int c);
        return 16'(c * 12059 + 4660);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic rs, input logic [3:0] rq,
                        input logic [3:0] e_gnt, input logic e_start, input logic e_clr,
                        input logic e_busy, input logic [3:0] e_vld);
        @(posedge clk);
        #1;
        rst      = r;
        restart  = rs;
        req      = rq;
        cyc++;
        gen_fp16 = fp_at(cyc);
        #1;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("gen_start", 32'(gen_start), 32'(e_start));
        check("gen_clr", 32'(gen_clr), 32'(e_clr));
        check("busy", 32'(busy), 32'(e_busy));
        check("smp_vld", 32'(smp_vld), 32'(e_vld));
        if (e_vld != 4'h0) begin
            last_data = fp_at(cyc);
        end
        check("smp_data", 32'(smp_data), 32'(last_data));
    endtask

    initial begin
        // Reset, then CLR, two WAIT cycles, one SKIP draw, RUN.
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, (i < 8) ? 4'hF : 4'h0, G_ALL[i], G_ALL[i] != 4'h0, 1'b0, 1'b0, V_ALL[i]);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, (i < 4) ? 4'h5 : 4'h0, G_ALT[i], G_ALT[i] != 4'h0, 1'b0, 1'b0, V_ALT[i]);
        end

        // Single-cycle request from requester 3.
        step(1'b0, 1'b0, 4'h8, 4'h8, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h8);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Two grants, then restart with requests still pending.
        step(1'b0, 1'b0, 4'hF, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1, 4'h0);

        // Round-robin pointer survives restart: resumes at requester 2.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, (i < 5) ? 4'hF : 4'h0, G_RS[i], G_RS[i] != 4'h0, 1'b0, 1'b0, V_RS[i]);
`ifdef SOBOL_SHARE_CNT_EN
            if (i == 5) begin
                check("pt_idx", pt_idx, 32'd6);
                check("sat", 32'(sat), 32'd0);
            end
`endif
        end

        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 4'h0);
`ifdef SOBOL_SHARE_CNT_EN
        check("pt_idx_clr", pt_idx, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
